// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: sequencer state encodings and per-stage enable/flush bundle
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID
module hazard_detect #(
  parameter int RW = 3
) (
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rd,
  output logic          lu_hz
);
  assign lu_hz = ex_mem_read && ex_rd != '0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer for load-use bubbles, branch flush and dmem wait
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REGADDR_WIDTH = 3,
  parameter int MEM_TIMEOUT   = 15,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [REGADDR_WIDTH-1:0] id_rs1,
  input  logic [REGADDR_WIDTH-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  input  logic                     mem_mem_read,
  input  logic                     mem_mem_write,
  input  logic                     mem_branch,
  input  logic                     mem_taken,
  input  logic                     dmem_ready,
  output logic                     dmem_req,
  output logic                     pc_write,
  output logic                     pc_sel,
  output logic                     if_id_en,
  output logic                     id_ex_en,
  output logic                     ex_mem_en,
  output logic                     mem_wb_en,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     ex_mem_flush,
  output logic                     mem_wb_flush,
  output logic [1:0]               ctrl_state,
  output logic                     timeout_err,
  output logic [CNT_WIDTH-1:0]     stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0]    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          memacc, lu_hz, tmo_hit, pcw, pcs, req;
  stage_t        en, fl;
  assign memacc = mem_mem_read | mem_mem_write;
  hazard_detect #(.RW(REGADDR_WIDTH)) u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .lu_hz      (lu_hz)
  );
  always_comb begin
    en        = '1;
    fl        = '0;
    pcw       = 1'b1;
    pcs       = 1'b0;
    req       = 1'b0;
    state_nxt = ST_RUN;
    wait_nxt  = '0;
    tmo_hit   = 1'b0;
    if (state == ST_RUN) begin
      req = memacc;
      if (memacc && !dmem_ready) begin
        en        = '0;
        pcw       = 1'b0;
        fl.mem_wb = 1'b1;
        state_nxt = ST_MEMWAIT;
        wait_nxt  = WW'(1);
      end else if (mem_branch && mem_taken) begin
        pcs       = 1'b1;
        fl.if_id  = 1'b1;
        fl.id_ex  = 1'b1;
        fl.ex_mem = 1'b1;
        state_nxt = ST_FLUSH;
      end else if (lu_hz) begin
        pcw      = 1'b0;
        en.if_id = 1'b0;
        fl.id_ex = 1'b1;
      end
    end else if (state == ST_MEMWAIT) begin
      req = 1'b1;
      // on timeout the squashed access is dropped and the rest of the pipe moves on
      if (!dmem_ready && wait_cnt == WW'(MEM_TIMEOUT)) begin
        tmo_hit   = 1'b1;
        fl.ex_mem = 1'b1;
        fl.mem_wb = 1'b1;
      end else if (!dmem_ready) begin
        en        = '0;
        pcw       = 1'b0;
        fl.mem_wb = 1'b1;
        state_nxt = ST_MEMWAIT;
        wait_nxt  = wait_cnt + 1'b1;
      end
    end else if (state == ST_FLUSH) begin
      fl.if_id = 1'b1;
    end
  end
  assign if_id_en     = reset_n & en.if_id;
  assign id_ex_en     = reset_n & en.id_ex;
  assign ex_mem_en    = reset_n & en.ex_mem;
  assign mem_wb_en    = reset_n & en.mem_wb;
  assign if_id_flush  = reset_n & fl.if_id;
  assign id_ex_flush  = reset_n & fl.id_ex;
  assign ex_mem_flush = reset_n & fl.ex_mem;
  assign mem_wb_flush = reset_n & fl.mem_wb;
  assign pc_write     = reset_n & pcw;
  assign pc_sel       = reset_n & pcs;
  assign dmem_req     = reset_n & req;
  assign ctrl_state   = state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      timeout_err <= timeout_err | tmo_hit;
      if (!pcw && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized and directed checks of two sequencer instances against a behavioural model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic mem_mem_read = 0, mem_mem_write = 0, mem_branch = 0, mem_taken = 0, dmem_ready = 1;
  logic [3:0] en_a, fl_a, en_b, fl_b;
  logic pcw_a, pcs_a, req_a, terr_a, pcw_b, pcs_b, req_b, terr_b;
  logic [1:0] cs_a, cs_b;
  logic [15:0] sc_a;
  logic [3:0] sc_b;
  logic [47:0] obs, expv;
  int n_checks = 0, n_err = 0;
  assign obs = {en_a, fl_a, pcw_a, pcs_a, req_a, cs_a, terr_a, sc_a,
                en_b, fl_b, pcw_b, pcs_b, req_b, cs_b, terr_b, sc_b};

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_taken(mem_taken), .dmem_ready(dmem_ready), .dmem_req(req_a), .pc_write(pcw_a),
    .pc_sel(pcs_a), .if_id_en(en_a[3]), .id_ex_en(en_a[2]), .ex_mem_en(en_a[1]), .mem_wb_en(en_a[0]),
    .if_id_flush(fl_a[3]), .id_ex_flush(fl_a[2]), .ex_mem_flush(fl_a[1]), .mem_wb_flush(fl_a[0]),
    .ctrl_state(cs_a), .timeout_err(terr_a), .stall_cycles(sc_a)
  );
  pipe_hazard_ctrl #(.MEM_TIMEOUT(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_taken(mem_taken), .dmem_ready(dmem_ready), .dmem_req(req_b), .pc_write(pcw_b),
    .pc_sel(pcs_b), .if_id_en(en_b[3]), .id_ex_en(en_b[2]), .ex_mem_en(en_b[1]), .mem_wb_en(en_b[0]),
    .if_id_flush(fl_b[3]), .id_ex_flush(fl_b[2]), .ex_mem_flush(fl_b[1]), .mem_wb_flush(fl_b[0]),
    .ctrl_state(cs_b), .timeout_err(terr_b), .stall_cycles(sc_b)
  );

  // waiting: a data access is outstanding; flushq: the redirect cycle after a taken branch is due
  typedef struct {bit waiting; bit flushq; int wcnt; bit terr; int stalls;} mst_t;
  mst_t ma, mb, na, nb;

  function automatic void model(input mst_t s, input int tmo, input int smax,
                                output logic [13:0] o, output mst_t n);
    bit memacc = mem_mem_read || mem_mem_write;
    bit hit1 = id_use_rs1 && id_rs1 == ex_rd;
    bit hit2 = id_use_rs2 && id_rs2 == ex_rd;
    bit lu = ex_mem_read && ex_rd != 0 && (hit1 || hit2);
    bit [3:0] en = 4'hF, fl = 4'h0;
    bit pcw = 1, pcs = 0, req = 0;
    int st = s.waiting ? 1 : s.flushq ? 2 : 0;
    n = s;
    if (!reset_n) begin
      o = '0;
      return;
    end
    if (s.waiting) begin
      req = 1;
      if (!dmem_ready && s.wcnt == tmo) begin
        fl = 4'b0011; n.terr = 1; n.waiting = 0; n.wcnt = 0;
      end else if (!dmem_ready) begin
        en = 0; pcw = 0; fl = 4'b0001; n.wcnt = s.wcnt + 1;
      end else begin
        n.waiting = 0; n.wcnt = 0;
      end
    end else if (s.flushq) begin
      fl = 4'b1000; n.flushq = 0;
    end else begin
      req = memacc;
      if (memacc && !dmem_ready) begin
        en = 0; pcw = 0; fl = 4'b0001; n.waiting = 1; n.wcnt = 1;
      end else if (mem_branch && mem_taken) begin
        pcs = 1; fl = 4'b1110; n.flushq = 1;
      end else if (lu) begin
        pcw = 0; en = 4'b0111; fl = 4'b0100;
      end
    end
    if (!pcw && n.stalls < smax) n.stalls = n.stalls + 1;
    o = {en, fl, pcw, pcs, req, 2'(st), s.terr};
  endfunction

  task automatic eval_m();
    logic [13:0] oa, ob;
    @(negedge clk);
    model(ma, 15, 65535, oa, na);
    model(mb, 2, 15, ob, nb);
    expv = {oa, 16'(ma.stalls), ob, 4'(mb.stalls)};
  endtask

  task automatic adv();
    @(posedge clk);
    ma = na;
    mb = nb;
    #1;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, mem_mem_read, mem_mem_write, mem_branch, mem_taken} = '0;
    dmem_ready = 1;
  endtask

  task automatic lu_in();
    ex_mem_read = 1; ex_rd = 3'd4; id_rs1 = 3'd4; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got %h exp 0", obs);
    end
    reset_n = 1;
  endtask

  task automatic test_load_use();
    // {rs1, rs2, use1, use2, ex_rd, stall expected}
    logic [12:0] tbl [5] = '{{3'd3, 3'd0, 2'b10, 3'd3, 1'b1}, {3'd0, 3'd0, 2'b11, 3'd0, 1'b0},
                             {3'd1, 3'd5, 2'b01, 3'd5, 1'b1}, {3'd1, 3'd5, 2'b10, 3'd5, 1'b0},
                             {3'd6, 3'd6, 2'b00, 3'd6, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      idle();
      {id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd} = tbl[i][12:1];
      ex_mem_read = 1;
      eval_m();
      n_checks += 2;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL load_use_model row %0d: got %h exp %h", i, obs, expv);
      end
      if ({pcw_a, en_a, fl_a} !== (tbl[i][0] ? 9'b0_0111_0100 : 9'b1_1111_0000)) begin
        n_err++;
        $display("FAIL load_use_ctrl row %0d: got %b stall %0d", i, {pcw_a, en_a, fl_a}, tbl[i][0]);
      end
      adv();
    end
    idle();
  endtask

  task automatic test_timeout();
    mem_mem_read = 1;
    dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      eval_m();
      n_checks += 2;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL timeout_model cycle %0d: got %h exp %h", i, obs, expv);
      end
      if ({fl_b[1], terr_b} !== {i == 2, i == 3}) begin
        n_err++;
        $display("FAIL timeout_pulse cycle %0d: got ex_mem_flush=%b err=%b", i, fl_b[1], terr_b);
      end
      adv();
    end
    idle();
    n_checks++;
    if ({terr_a, terr_b} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b exp 01", {terr_a, terr_b});
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] s0;
    idle();
    s0 = sc_a;
    mem_mem_write = 1;
    for (int i = 0; i < 5; i++) begin
      dmem_ready = (i >= 3);
      mem_mem_write = (i < 4);
      eval_m();
      n_checks += 2;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL mem_wait_model cycle %0d: got %h exp %h", i, obs, expv);
      end
      if ({en_a == 4'h0, cs_a} !== {i < 3, (i >= 1 && i <= 3) ? 2'd1 : 2'd0}) begin
        n_err++;
        $display("FAIL mem_wait_state cycle %0d: got en=%b state=%0d", i, en_a, cs_a);
      end
      adv();
    end
    n_checks++;
    if (sc_a - s0 !== 16'd3) begin
      n_err++;
      $display("FAIL mem_wait_stalls: got %0d exp 3", sc_a - s0);
    end
    idle();
  endtask

  task automatic test_branch(input bit with_lu);
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i < 2) begin
        mem_branch = 1; mem_taken = 1;
        if (with_lu) lu_in();
      end
      eval_m();
      n_checks += 2;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL branch_model lu=%0d cycle %0d: got %h exp %h", with_lu, i, obs, expv);
      end
      if ({cs_a, pcw_a, pcs_a, en_a, fl_a} !== (i == 0 ? 12'b00_11_1111_1110 :
                                                i == 1 ? 12'b10_10_1111_1000 :
                                                with_lu ? 12'b00_10_1111_0000 : 12'b00_10_1111_0000)) begin
        n_err++;
        $display("FAIL branch_ctrl lu=%0d cycle %0d: got %b", with_lu, i, {cs_a, pcw_a, pcs_a, en_a, fl_a});
      end
      adv();
    end
  endtask

  task automatic test_saturate();
    idle();
    lu_in();
    for (int i = 0; i < 20; i++) begin
      eval_m();
      n_checks++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL saturate_model cycle %0d: got %h exp %h", i, obs, expv);
      end
      adv();
    end
    n_checks++;
    if (sc_b !== 4'hF) begin
      n_err++;
      $display("FAIL saturate_cnt: got %0d exp 15", sc_b);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 3'($urandom_range(0, 3));
      id_rs2 = 3'($urandom_range(0, 3));
      ex_rd = 3'($urandom_range(0, 3));
      {id_use_rs1, id_use_rs2, ex_mem_read, mem_taken} = 4'($urandom);
      mem_mem_read = $urandom_range(0, 3) == 0;
      mem_mem_write = $urandom_range(0, 5) == 0;
      mem_branch = $urandom_range(0, 2) == 0;
      dmem_ready = $urandom_range(0, 3) != 0;
      eval_m();
      n_checks++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL random cycle %0d: got %h exp %h", i, obs, expv);
      end
      adv();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    mem_mem_read = 1;
    dmem_ready = 0;
    eval_m();
    adv();
    n_checks++;
    if ({req_a, cs_a} !== 3'b101) begin
      n_err++;
      $display("FAIL reset_mid_pre: got req=%b state=%0d exp 1/1", req_a, cs_a);
    end
    #2 reset_n = 0;
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    n_checks++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %h exp 0", obs);
    end
    @(posedge clk);
    #1 reset_n = 1;
    idle();
    eval_m();
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL reset_mid_after: got %h exp %h", obs, expv);
    end
    adv();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_timeout();
    test_mem_wait();
    test_branch(0);
    test_branch(1);
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
